tile_raster_mapper: RTL and testbench

TILE_RASTER_MAPPER -- requirements
Module: tile_raster_mapper

---
 rtl/tile_raster_mapper.sv | 162 ++++++++++++++++
 tb/tb_tile_raster_mapper.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tile_raster_mapper.sv
// Raster scan counter with incremental board-cell tracking (no divide/multiply).
// Every output is registered and describes the same pixel in the same cycle.
module tile_raster_mapper #(
  parameter int H_RES = 128,
  parameter int V_RES = 160,
  parameter int CELL  = 12,
  parameter int COLS  = 10,
  parameter int ROWS  = 12,
  parameter int X_OFF = 4,
  parameter int Y_OFF = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pixel_req,
  output logic [12:0] x_pos,
  output logic [12:0] y_pos,
  output logic [4:0]  q_x,
  output logic [4:0]  q_y,
  output logic [7:0]  sub_x,
  output logic [7:0]  sub_y,
  output logic        in_board,
  output logic        grid,
  output logic        frame_done
);

  if (X_OFF + COLS*CELL > H_RES || Y_OFF + ROWS*CELL > V_RES ||
      COLS > 32 || ROWS > 32 || CELL > 256) begin : g_cfg_check
    $error("tile_raster_mapper: illegal board geometry");
  end

  localparam logic [12:0] X_LAST   = 13'(H_RES - 1);
  localparam logic [12:0] Y_LAST   = 13'(V_RES - 1);
  localparam logic [12:0] X_BEG    = 13'(X_OFF);
  localparam logic [12:0] Y_BEG    = 13'(Y_OFF);
  localparam logic [12:0] X_END    = 13'(X_OFF + COLS*CELL);
  localparam logic [12:0] Y_END    = 13'(Y_OFF + ROWS*CELL);
  localparam logic [7:0]  SUB_LAST = 8'(CELL - 1);
  localparam logic        X_AT_0   = (X_OFF == 0);
  localparam logic        Y_AT_0   = (Y_OFF == 0);

  // Tracking state always describes the current pixel; the output registers
  // are a masked copy so reset can force them to zero independently.
  logic [12:0] x_r, y_r, x_n, y_n;
  logic [4:0]  cx_r, cy_r, cx_n, cy_n;
  logic [7:0]  sx_r, sy_r, sx_n, sy_n;
  logic        in_x_r, in_y_r, in_x_n, in_y_n;
  logic        done_n, inb_n, upd;

  always_comb begin
    x_n    = x_r;
    y_n    = y_r;
    cx_n   = cx_r;
    cy_n   = cy_r;
    sx_n   = sx_r;
    sy_n   = sy_r;
    in_x_n = in_x_r;
    in_y_n = in_y_r;
    done_n = 1'b0;
    upd    = frame_start | pixel_req;
    if (frame_start) begin
      x_n    = '0;
      y_n    = '0;
      cx_n   = '0;
      sx_n   = '0;
      cy_n   = '0;
      sy_n   = '0;
      in_x_n = X_AT_0;
      in_y_n = Y_AT_0;
    end else if (pixel_req) begin
      if (x_r == X_LAST) begin
        x_n    = '0;
        cx_n   = '0;
        sx_n   = '0;
        in_x_n = X_AT_0;
        if (y_r == Y_LAST) begin
          y_n    = '0;
          cy_n   = '0;
          sy_n   = '0;
          in_y_n = Y_AT_0;
          done_n = 1'b1;
        end else begin
          y_n = y_r + 13'd1;
          if (y_n == Y_BEG)      in_y_n = 1'b1;
          else if (y_n == Y_END) in_y_n = 1'b0;
          if (!(in_y_n && in_y_r)) begin
            cy_n = '0;
            sy_n = '0;
          end else if (sy_r == SUB_LAST) begin
            cy_n = cy_r + 5'd1;
            sy_n = '0;
          end else begin
            sy_n = sy_r + 8'd1;
          end
        end
      end else begin
        x_n = x_r + 13'd1;
        if (x_n == X_BEG)      in_x_n = 1'b1;
        else if (x_n == X_END) in_x_n = 1'b0;
        if (!(in_x_n && in_x_r)) begin
          cx_n = '0;
          sx_n = '0;
        end else if (sx_r == SUB_LAST) begin
          cx_n = cx_r + 5'd1;
          sx_n = '0;
        end else begin
          sx_n = sx_r + 8'd1;
        end
      end
    end
    inb_n = in_x_n & in_y_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= '0;
      y_r    <= '0;
      cx_r   <= '0;
      cy_r   <= '0;
      sx_r   <= '0;
      sy_r   <= '0;
      in_x_r <= X_AT_0;
      in_y_r <= Y_AT_0;
    end else begin
      x_r    <= x_n;
      y_r    <= y_n;
      cx_r   <= cx_n;
      cy_r   <= cy_n;
      sx_r   <= sx_n;
      sy_r   <= sy_n;
      in_x_r <= in_x_n;
      in_y_r <= in_y_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_pos      <= '0;
      y_pos      <= '0;
      q_x        <= '0;
      q_y        <= '0;
      sub_x      <= '0;
      sub_y      <= '0;
      in_board   <= 1'b0;
      grid       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_n;
      if (upd) begin
        x_pos    <= x_n;
        y_pos    <= y_n;
        q_x      <= inb_n ? cx_n : 5'd0;
        q_y      <= inb_n ? cy_n : 5'd0;
        sub_x    <= inb_n ? sx_n : 8'd0;
        sub_y    <= inb_n ? sy_n : 8'd0;
        in_board <= inb_n;
        grid     <= inb_n & ((sx_n == 8'd0) | (sy_n == 8'd0));
      end
    end
  end

endmodule

// File: tb/tb_tile_raster_mapper.sv
// Directed bench for tile_raster_mapper: stimulus pushes hand-computed pixel
// snapshots into a queue; a negedge monitor pops and compares them.
module tb_tile_raster_mapper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic [12:0] x_pos, y_pos;
  logic [4:0]  q_x, q_y;
  logic [7:0]  sub_x, sub_y;
  logic        in_board, grid, frame_done;

  tile_raster_mapper dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pixel_req(pixel_req),
    .x_pos(x_pos), .y_pos(y_pos), .q_x(q_x), .q_y(q_y), .sub_x(sub_x), .sub_y(sub_y),
    .in_board(in_board), .grid(grid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] x;
    logic [12:0] y;
    logic [4:0]  qx;
    logic [4:0]  qy;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic        inb;
    logic        grid;
    logic        done;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{x_pos, y_pos, q_x, q_y, sub_x, sub_y, in_board, grid, frame_done};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got x=%0d y=%0d q=(%0d,%0d) sub=(%0d,%0d) inb=%b grid=%b done=%b, want x=%0d y=%0d q=(%0d,%0d) sub=(%0d,%0d) inb=%b grid=%b done=%b",
                 n, a.x, a.y, a.qx, a.qy, a.sx, a.sy, a.inb, a.grid, a.done,
                 e.x, e.y, e.qx, e.qy, e.sx, e.sy, e.inb, e.grid, e.done);
      end
    end
  end

  task automatic expect_px(input string n, input int x, input int y, input int qx, input int qy,
                           input int sx, input int sy, input bit inb, input bit g, input bit d);
    obs_t e;
    e = '{13'(x), 13'(y), 5'(qx), 5'(qy), 8'(sx), 8'(sy), inb, g, d};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic adv(input int n);
    @(negedge clk);
    pixel_req = 1'b1;
    repeat (n) @(posedge clk);
    #1 pixel_req = 1'b0;
  endtask

  task automatic start_frame(input bit with_req);
    @(negedge clk);
    frame_start = 1'b1;
    pixel_req   = with_req;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pixel_req   = 1'b0;
  endtask

  initial begin
    #2;
    expect_px("reset_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    start_frame(1'b0);
    expect_px("frame_start_origin", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    adv(1028);
    expect_px("board_corner", 4, 8, 0, 0, 0, 0, 1, 1, 0);
    adv(12);
    expect_px("second_cell", 16, 8, 1, 0, 0, 0, 1, 1, 0);
    adv(11);
    expect_px("cell_end_top_row", 27, 8, 1, 0, 11, 0, 1, 1, 0);
    adv(96);
    expect_px("right_edge_in", 123, 8, 9, 0, 11, 0, 1, 1, 0);
    adv(1);
    expect_px("right_edge_out", 124, 8, 0, 0, 0, 0, 0, 0, 0);
    adv(34);
    expect_px("interior_no_grid", 30, 9, 2, 0, 2, 1, 1, 0, 0);
    adv(2708);
    expect_px("mid_board", 50, 30, 3, 1, 10, 10, 1, 0, 0);
    @(posedge clk);
    #1 expect_px("idle_hold", 50, 30, 3, 1, 10, 10, 1, 0, 0);

    start_frame(1'b1);
    expect_px("start_beats_req", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    adv(20479);
    expect_px("last_pixel", 127, 159, 0, 0, 0, 0, 0, 0, 0);
    adv(1);
    expect_px("wrap_done_high", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1 expect_px("wrap_done_low", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    adv(2564);
    expect_px("second_cell_row", 4, 20, 0, 1, 0, 0, 1, 1, 0);
    adv(16768);
    expect_px("bottom_row", 4, 151, 0, 11, 0, 11, 1, 1, 0);
    adv(128);
    expect_px("below_board", 4, 152, 0, 0, 0, 0, 0, 0, 0);

    start_frame(1'b0);
    adv(11590);
    expect_px("pre_reset", 70, 90, 5, 6, 6, 10, 1, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    expect_px("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    adv(1);
    expect_px("resume_after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
